// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared widths, types and pointer helper for the sync_fifo slice.
// Data width, depth and pointer width are fixed here so that the FIFO control
// block and its storage RAM always agree on geometry.
package sync_fifo_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  // Advance a storage pointer by one, wrapping from the last address to zero.
  // The wrap is explicit so that a depth which is not a power of two still works.
  function automatic ptr_t ptr_inc(input ptr_t ptr, input ptr_t last_addr);
    ptr_t nxt;
    if (ptr == last_addr) begin
      nxt = '0;
    end else begin
      nxt = ptr + ptr_t'(1'b1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_W storage array for sync_fifo.
// Synchronous write, asynchronous array read; the FIFO registers the read
// value itself. Contents are never cleared, so reset does not touch this array.
module fifo_ram
  import sync_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Write port: store one word per accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_chk.sv
// sync_fifo_chk: structural invariants of the sync_fifo control state.
// Watches occupancy and accept strobes; holds no state of its own.
module sync_fifo_chk
  import sync_fifo_pkg::*;
(
  input logic clk,
  input logic rst,
  input cnt_t count,
  input logic full,
  input logic empty,
  input logic wr_en,
  input logic rd_en
);

  // Occupancy can never exceed the number of storage entries.
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    count <= cnt_t'(DEPTH));

  // Full and empty are mutually exclusive for a non-zero depth.
  a_full_empty: assert property (@(posedge clk) disable iff (rst)
    !(full && empty));

  // An accepted write never lands on a full FIFO.
  a_no_wr_full: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && full));

  // An accepted read never comes from an empty FIFO.
  a_no_rd_empty: assert property (@(posedge clk) disable iff (rst)
    !(rd_en && empty));

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO control (pointers, occupancy, status and error flags).
// Storage lives in fifo_ram (instance mem1). Data width and depth come from
// sync_fifo_pkg. Read data is registered with one cycle of latency.
// Optional build macro FIFO_STICKY_ERR_EN: when defined, fifo_overflow and
// fifo_underflow stay set once raised until rst; otherwise they are
// single-cycle pulses.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int THRESHOLD = 8,
  parameter int MAX_PTR   = DEPTH - 1
) (
  input  logic              wr,
  input  logic              rd,
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_threshold,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam ptr_t LAST_ADDR = ptr_t'(MAX_PTR);
  localparam cnt_t FULL_CNT  = cnt_t'(DEPTH);
  localparam cnt_t THR_CNT   = cnt_t'(THRESHOLD);

  // Registered state
  ptr_t  wptr_r;
  ptr_t  rptr_r;
  cnt_t  count_r;
  data_t data_out_r;
  logic  overflow_r;
  logic  underflow_r;

  // Combinational decode
  logic  full_s;
  logic  empty_s;
  logic  threshold_s;
  logic  wr_en_s;
  logic  rd_en_s;
  ptr_t  wptr_nxt_s;
  ptr_t  rptr_nxt_s;
  cnt_t  count_nxt_s;
  logic  overflow_nxt_s;
  logic  underflow_nxt_s;
  data_t ram_rdata_s;

  // Status flags are decoded straight from the registered occupancy.
  always_comb begin
    full_s      = (count_r == FULL_CNT);
    empty_s     = (count_r == cnt_t'(1'b0));
    threshold_s = (count_r >= THR_CNT);
  end

  // Accept decisions: a full FIFO refuses writes, an empty one refuses reads.
  // Both are judged on the current count, so wr&rd on a full FIFO still drains
  // one entry and wr&rd on an empty FIFO still stores one.
  always_comb begin
    wr_en_s = wr & ~full_s;
    rd_en_s = rd & ~empty_s;
  end

  // Pointer advance only for accepted accesses.
  always_comb begin
    if (wr_en_s) begin
      wptr_nxt_s = ptr_inc(wptr_r, LAST_ADDR);
    end else begin
      wptr_nxt_s = wptr_r;
    end
    if (rd_en_s) begin
      rptr_nxt_s = ptr_inc(rptr_r, LAST_ADDR);
    end else begin
      rptr_nxt_s = rptr_r;
    end
  end

  // Occupancy update: a simultaneous accepted write and read cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_nxt_s = count_r + cnt_t'(1'b1);
      2'b01:   count_nxt_s = count_r - cnt_t'(1'b1);
      2'b11:   count_nxt_s = count_r;
      2'b00:   count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
  end

  // Error flag next-state: pulse per offending edge, or accumulate when sticky.
  always_comb begin
`ifdef FIFO_STICKY_ERR_EN
    overflow_nxt_s  = overflow_r  | (wr & full_s);
    underflow_nxt_s = underflow_r | (rd & empty_s);
`else
    overflow_nxt_s  = wr & full_s;
    underflow_nxt_s = rd & empty_s;
`endif
  end

  // Control state: pointers, occupancy and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r      <= '0;
      rptr_r      <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wptr_r      <= wptr_nxt_s;
      rptr_r      <= rptr_nxt_s;
      count_r     <= count_nxt_s;
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  // Read data register: loads only on an accepted read, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r <= '0;
    end else if (rd_en_s) begin
      data_out_r <= ram_rdata_s;
    end else begin
      data_out_r <= data_out_r;
    end
  end

  fifo_ram mem1 (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wptr_r),
    .wdata (data_in),
    .raddr (rptr_r),
    .rdata (ram_rdata_s)
  );

  sync_fifo_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .count (count_r),
    .full  (full_s),
    .empty (empty_s),
    .wr_en (wr_en_s),
    .rd_en (rd_en_s)
  );

  assign data_out       = data_out_r;
  assign fifo_full      = full_s;
  assign fifo_empty     = empty_s;
  assign fifo_threshold = threshold_s;
  assign fifo_overflow  = overflow_r;
  assign fifo_underflow = underflow_r;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo with a queue scoreboard.
// Accepted writes push the written byte; accepted reads pop the byte that the
// registered data_out must show one edge later. Honours FIFO_STICKY_ERR_EN.
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       wr;
  logic       rd;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_threshold;
  logic       fifo_overflow;
  logic       fifo_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard and expected observable state
  logic [7:0] sb_q[$];
  logic [7:0] exp_dout;
  logic       exp_ov;
  logic       exp_un;

  sync_fifo dut (
    .wr             (wr),
    .rd             (rd),
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_out       (data_out),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_threshold (fifo_threshold),
    .fifo_overflow  (fifo_overflow),
    .fifo_underflow (fifo_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output with the model after an edge.
  task automatic check_all(input string tag);
    int sz;
    sz = sb_q.size();
    chk({tag, ".dout"},  data_out, exp_dout);
    chk({tag, ".full"},  {7'd0, fifo_full},      {7'd0, sz == 16});
    chk({tag, ".empty"}, {7'd0, fifo_empty},     {7'd0, sz == 0});
    chk({tag, ".thr"},   {7'd0, fifo_threshold}, {7'd0, sz >= 8});
    chk({tag, ".ovf"},   {7'd0, fifo_overflow},  {7'd0, exp_ov});
    chk({tag, ".unf"},   {7'd0, fifo_underflow}, {7'd0, exp_un});
  endtask

  // One clock with the given request pattern; model updated from pre-edge state.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input string tag);
    logic was_full;
    logic was_empty;
    was_full  = (sb_q.size() == 16);
    was_empty = (sb_q.size() == 0);
    wr = w;
    rd = r;
    data_in = d;
    @(posedge clk);
    if (r && !was_empty) exp_dout = sb_q.pop_front();
    if (w && !was_full)  sb_q.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
    exp_ov = exp_ov | (w & was_full);
    exp_un = exp_un | (r & was_empty);
`else
    exp_ov = w & was_full;
    exp_un = r & was_empty;
`endif
    #1;
    wr = 1'b0;
    rd = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input logic w, input logic r, input string tag);
    rst = 1'b1;
    wr = w;
    rd = r;
    data_in = 8'hA5;
    @(posedge clk);
    sb_q.delete();
    exp_dout = 8'h00;
    exp_ov = 1'b0;
    exp_un = 1'b0;
    #1;
    rst = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    data_in = 8'h00;
    exp_dout = 8'h00;
    exp_ov = 1'b0;
    exp_un = 1'b0;

    // Reset state (requests held high to show reset wins)
    do_reset(1'b1, 1'b1, "reset");

    // 20 writes: 16 accepted, threshold after 8th, full after 16th, overflow on 17-20
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'(i), "fill");

    // 20 reads: 0..15 in order, underflow on 17-20, data_out holds 15
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h00, "drain");
    chk("drain.hold", data_out, 8'd15);

    // Reset with FIFO half full
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h40 + i), "half");
    do_reset(1'b0, 1'b0, "rst_half");

    // Move pointers to mid-array so the streaming phase crosses the wrap
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h50 + i), "offs_w");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, "offs_r");

    // Load 5, then 10 simultaneous read/write cycles; count must stay 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i), "load5");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'(8'h70 + i), "stream");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, "tail");
    chk("tail.last", data_out, 8'h79);

    // wr&rd on empty: write accepted, underflow raised
    step(1'b1, 1'b1, 8'hC3, "rw_empty");
    step(1'b0, 1'b1, 8'h00, "rw_empty_rd");
    chk("rw_empty.data", data_out, 8'hC3);

    // wr&rd on full: read accepted, overflow raised, count drops to 15
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h80 + i), "refill");
    step(1'b1, 1'b1, 8'hEE, "rw_full");
    chk("rw_full.data", data_out, 8'h80);
    step(1'b0, 1'b0, 8'h00, "idle_after");
    step(1'b1, 1'b0, 8'h9F, "top_up");

    // Final reset clears any flag, sticky or not
    do_reset(1'b0, 1'b0, "rst_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
